// File: rtl/trace_pkg.sv
// Shared definitions for the retirement trace checker: error bit positions,
// the buffered error record layout, checker states and the mask legality rule.
package trace_pkg;

    localparam int ERR_ORDER = 0;
    localparam int ERR_PC    = 1;
    localparam int ERR_X0    = 2;
    localparam int ERR_MASK  = 3;
    localparam int ERR_ALIGN = 4;
    localparam int ERR_HALT  = 5;
    localparam int ERR_W     = 6;

    typedef struct packed {
        logic [ERR_W-1:0] code;
        logic [63:0]      order;
        logic [31:0]      pc;
        logic [31:0]      insn;
    } err_rec_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } chk_state_e;

    // A byte mask is legal when it describes a naturally aligned byte,
    // halfword or word access, or no access at all.
    function automatic logic legal_mask(input logic [3:0] mask);
        logic ok;
        case (mask)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with wrap-bit pointers. A push is accepted when the
// FIFO has room or when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; clear wins over any simultaneous push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/trace_checker.sv
// Retirement trace checker: validates every retired record against the
// architectural invariants and queues one error record per failing retire.
module trace_checker
    import trace_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             valid,
    input  logic [63:0]      order,
    input  logic [31:0]      insn,
    input  logic             trap,
    input  logic             halt,
    input  logic             intr,
    input  logic [4:0]       rd_addr,
    input  logic [31:0]      rd_wdata,
    input  logic [31:0]      pc_rdata,
    input  logic [31:0]      pc_wdata,
    input  logic [3:0]       mem_rmask,
    input  logic [3:0]       mem_wmask,
    output logic             err_valid,
    input  logic             err_ready,
    output logic [5:0]       err_code,
    output logic [63:0]      err_order,
    output logic [31:0]      err_pc,
    output logic [31:0]      err_insn,
    output logic [5:0]       err_sticky,
    output logic             err_overflow,
    output logic [CNT_W-1:0] retire_count,
    output logic             halted
);

    chk_state_e       state;
    chk_state_e       state_next;
    logic [63:0]      exp_order;
    logic [31:0]      prev_pc;
    logic [ERR_W-1:0] code;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    err_rec_t         rec_in;
    err_rec_t         rec_out;

    // Evaluate every invariant for the record on the bus this cycle.
    always_comb begin
        code = '0;
        if (valid) begin
            code[ERR_ORDER] = (order != exp_order);
            code[ERR_PC]    = (state != IDLE) && !intr && (pc_rdata != prev_pc);
            code[ERR_X0]    = (rd_addr == 5'd0) && (rd_wdata != 32'd0);
            code[ERR_MASK]  = !legal_mask(mem_rmask) || !legal_mask(mem_wmask) ||
                              ((mem_rmask != 4'd0) && (mem_wmask != 4'd0));
            code[ERR_ALIGN] = !trap && (pc_wdata[1:0] != 2'b00);
            code[ERR_HALT]  = (state == HALTED);
        end
    end

    assign push   = (code != '0);
    assign pop    = err_ready && !empty;
    assign rec_in = '{code: code, order: order, pc: pc_rdata, insn: insn};

    sync_fifo #(
        .WIDTH ($bits(err_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (push),
        .push_data (rec_in),
        .full      (full),
        .pop       (pop),
        .pop_data  (rec_out),
        .empty     (empty)
    );

    // State register for the IDLE/RUN/HALTED lifecycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state <= IDLE;
        else if (clr) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state: first record starts the run, a halt record ends it for good.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid)         state_next = RUN;
            RUN:     if (valid && halt) state_next = HALTED;
            HALTED:                     state_next = HALTED;
            default:                    state_next = IDLE;
        endcase
    end

    // Per-retire tracking: count, expected order from the received one, next PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count <= '0;
            exp_order    <= '0;
            prev_pc      <= '0;
        end else if (clr) begin
            retire_count <= '0;
            exp_order    <= '0;
            prev_pc      <= '0;
        end else if (valid) begin
            retire_count <= retire_count + CNT_W'(1);
            exp_order    <= order + 64'd1;
            prev_pc      <= pc_wdata;
        end
    end

    // Sticky summaries: every detected code bit, and any dropped record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky   <= '0;
            err_overflow <= 1'b0;
        end else if (clr) begin
            err_sticky   <= '0;
            err_overflow <= 1'b0;
        end else begin
            err_sticky <= err_sticky | code;
            if (push && full && !pop) err_overflow <= 1'b1;
        end
    end

    assign err_valid = !empty;
    assign err_code  = empty ? '0 : rec_out.code;
    assign err_order = empty ? '0 : rec_out.order;
    assign err_pc    = empty ? '0 : rec_out.pc;
    assign err_insn  = empty ? '0 : rec_out.insn;
    assign halted    = (state == HALTED);

endmodule

// File: tb/tb_trace_checker.sv
// Self-checking bench for trace_checker: directed scenarios followed by a
// randomized burst, all compared against a queue-based reference model.
module tb_trace_checker;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [5:0]  code;
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
    } tb_rec_t;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic        err_valid;
    logic        err_ready;
    logic [5:0]  err_code;
    logic [63:0] err_order;
    logic [31:0] err_pc;
    logic [31:0] err_insn;
    logic [5:0]  err_sticky;
    logic        err_overflow;
    logic [63:0] retire_count;
    logic        halted;

    int checks;
    int errors;

    // Reference model state
    tb_rec_t     m_q[$];
    logic [63:0] m_exp_order;
    logic [31:0] m_prev_pc;
    logic [63:0] m_count;
    logic [5:0]  m_sticky;
    bit          m_overflow;
    bit          m_started;
    bit          m_stopped;

    logic [3:0] legal_list [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                   4'b1000, 4'b0011, 4'b1100, 4'b1111};

    trace_checker #(.FIFO_DEPTH(DEPTH), .CNT_W(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .valid        (valid),
        .order        (order),
        .insn         (insn),
        .trap         (trap),
        .halt         (halt),
        .intr         (intr),
        .rd_addr      (rd_addr),
        .rd_wdata     (rd_wdata),
        .pc_rdata     (pc_rdata),
        .pc_wdata     (pc_wdata),
        .mem_rmask    (mem_rmask),
        .mem_wmask    (mem_wmask),
        .err_valid    (err_valid),
        .err_ready    (err_ready),
        .err_code     (err_code),
        .err_order    (err_order),
        .err_pc       (err_pc),
        .err_insn     (err_insn),
        .err_sticky   (err_sticky),
        .err_overflow (err_overflow),
        .retire_count (retire_count),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit mask_ok(input logic [3:0] m);
        return m inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                         4'b0011, 4'b1100, 4'b1111};
    endfunction

    function automatic logic [5:0] model_code();
        logic [5:0] c;
        c = '0;
        if (order != m_exp_order)                             c[0] = 1'b1;
        if (m_started && !intr && pc_rdata != m_prev_pc)      c[1] = 1'b1;
        if (rd_addr == 5'd0 && rd_wdata != 32'd0)             c[2] = 1'b1;
        if (!mask_ok(mem_rmask) || !mask_ok(mem_wmask) ||
            (mem_rmask != 4'd0 && mem_wmask != 4'd0))         c[3] = 1'b1;
        if (!trap && pc_wdata[1:0] != 2'b00)                  c[4] = 1'b1;
        if (m_stopped)                                        c[5] = 1'b1;
        return c;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_exp_order = '0;
        m_prev_pc   = '0;
        m_count     = '0;
        m_sticky    = '0;
        m_overflow  = 1'b0;
        m_started   = 1'b0;
        m_stopped   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [5:0] c;
        if (clr) begin
            model_reset();
            return;
        end
        if (m_q.size() > 0 && err_ready) void'(m_q.pop_front());
        if (valid) begin
            c = model_code();
            if (c != 6'd0) begin
                m_sticky = m_sticky | c;
                if (m_q.size() < DEPTH) m_q.push_back('{code: c, order: order, pc: pc_rdata, insn: insn});
                else                    m_overflow = 1'b1;
            end
            m_count     = m_count + 64'd1;
            m_exp_order = order + 64'd1;
            m_prev_pc   = pc_wdata;
            if (m_started && halt) m_stopped = 1'b1;
            m_started = 1'b1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        tb_rec_t head;
        head = (m_q.size() > 0) ? m_q[0] : '0;
        check_eq("err_valid",    {63'd0, err_valid},    {63'd0, m_q.size() > 0});
        check_eq("err_code",     {58'd0, err_code},     {58'd0, head.code});
        check_eq("err_order",    err_order,             head.order);
        check_eq("err_pc",       {32'd0, err_pc},       {32'd0, head.pc});
        check_eq("err_insn",     {32'd0, err_insn},     {32'd0, head.insn});
        check_eq("err_sticky",   {58'd0, err_sticky},   {58'd0, m_sticky});
        check_eq("err_overflow", {63'd0, err_overflow}, {63'd0, m_overflow});
        check_eq("retire_count", retire_count,          m_count);
        check_eq("halted",       {63'd0, halted},       {63'd0, m_stopped});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_output();
        clr = 1'b0;
    endtask

    // Drive a record that satisfies every invariant given the model history.
    task automatic apply_stimulus();
        int k;
        valid     = 1'b1;
        order     = m_exp_order;
        pc_rdata  = m_prev_pc;
        pc_wdata  = m_prev_pc + 32'd4;
        insn      = $urandom;
        rd_addr   = 5'($urandom_range(1, 31));
        rd_wdata  = $urandom;
        trap      = 1'b0;
        halt      = 1'b0;
        intr      = 1'b0;
        mem_rmask = 4'd0;
        mem_wmask = 4'd0;
        k = $urandom_range(0, 7);
        case ($urandom_range(0, 2))
            0:       mem_rmask = legal_list[k];
            1:       mem_wmask = legal_list[k];
            default: ;
        endcase
    endtask

    task automatic idle_bus();
        valid = 1'b0;
        order = 64'($urandom);
        halt  = $urandom_range(0, 1) == 1;
    endtask

    task automatic do_clear();
        idle_bus();
        clr = 1'b1;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; clr = 1'b0; valid = 1'b0; order = '0; insn = '0;
        trap = 1'b0; halt = 1'b0; intr = 1'b0; rd_addr = '0; rd_wdata = '0;
        pc_rdata = '0; pc_wdata = '0; mem_rmask = '0; mem_wmask = '0;
        err_ready = 1'b0;
        model_reset();

        // Reset state
        #12;
        check_output();
        check_eq("reset_err_valid", {63'd0, err_valid}, 64'd0);
        rst_n = 1'b1;
        #10;

        // Clean stream of ten records
        err_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus();
            step();
        end
        check_eq("clean_count",  retire_count, 64'd10);
        check_eq("clean_sticky", {58'd0, err_sticky}, 64'd0);

        // Order skip: 0, 1, 3, 4
        do_clear();
        err_ready = 1'b0;
        apply_stimulus(); step();
        apply_stimulus(); step();
        apply_stimulus(); order = 64'd3; step();
        check_eq("skip_valid", {63'd0, err_valid}, 64'd1);
        check_eq("skip_code",  {58'd0, err_code}, 64'h01);
        check_eq("skip_order", err_order, 64'd3);
        apply_stimulus(); step();
        err_ready = 1'b1; idle_bus(); step();
        check_eq("skip_single", {63'd0, err_valid}, 64'd0);

        // x0 write and illegal store mask in one retire
        err_ready = 1'b0;
        apply_stimulus();
        rd_addr = 5'd0; rd_wdata = 32'h5; mem_rmask = 4'd0; mem_wmask = 4'b0101;
        step();
        check_eq("x0mask_code", {58'd0, err_code}, 64'h0C);
        err_ready = 1'b1; idle_bus(); step();

        // Interrupt redirect suppresses the PC chain check
        do_clear();
        apply_stimulus(); pc_wdata = 32'h20; step();
        apply_stimulus(); pc_rdata = 32'h100; pc_wdata = 32'h104; intr = 1'b1; step();
        check_eq("intr_no_err", {63'd0, err_valid}, 64'd0);
        do_clear();
        err_ready = 1'b0;
        apply_stimulus(); pc_wdata = 32'h20; step();
        apply_stimulus(); pc_rdata = 32'h100; pc_wdata = 32'h104; step();
        check_eq("pc_err_code", {58'd0, err_code}, 64'h02);
        err_ready = 1'b1; idle_bus(); step();

        // Overflow with a full FIFO, then push+pop while full
        do_clear();
        err_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(); rd_addr = 5'd0; rd_wdata = 32'h1; step();
        end
        check_eq("ovf_flag", {63'd0, err_overflow}, 64'd1);
        check_eq("ovf_head", err_order, 64'd0);
        err_ready = 1'b1;
        apply_stimulus(); rd_addr = 5'd0; rd_wdata = 32'h1; step();
        check_eq("pushpop_head", err_order, 64'd1);
        for (int i = 0; i < 4; i++) begin
            idle_bus(); step();
        end
        check_eq("drain_empty", {63'd0, err_valid}, 64'd0);

        // Halt, then a retire after halt, then async reset mid-burst
        do_clear();
        err_ready = 1'b0;
        apply_stimulus(); step();
        apply_stimulus(); halt = 1'b1; step();
        check_eq("halted_set", {63'd0, halted}, 64'd1);
        apply_stimulus(); step();
        check_eq("halt_code", {58'd0, err_code}, 64'h20);
        apply_stimulus(); step();
        apply_stimulus();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_output();
        check_eq("arst_count",  retire_count, 64'd0);
        check_eq("arst_halted", {63'd0, halted}, 64'd0);
        check_eq("arst_valid",  {63'd0, err_valid}, 64'd0);
        rst_n = 1'b1;
        idle_bus();
        step();

        // Randomized mix of clean and corrupted records
        for (int i = 0; i < 400; i++) begin
            err_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 2) begin
                idle_bus();
                clr = 1'b1;
            end else if ($urandom_range(0, 4) == 0) begin
                idle_bus();
            end else begin
                apply_stimulus();
                if ($urandom_range(0, 99) < 3) halt = 1'b1;
                if ($urandom_range(0, 9) == 0) begin
                    intr = 1'b1;
                    pc_rdata = {$urandom_range(0, 1023), 2'b00};
                end
                if ($urandom_range(0, 3) == 0) begin
                    case ($urandom_range(0, 5))
                        0: order = order + 64'($urandom_range(1, 3));
                        1: pc_rdata = pc_rdata ^ 32'h10;
                        2: begin rd_addr = 5'd0; rd_wdata = $urandom | 32'h1; end
                        3: begin mem_rmask = 4'b0110; mem_wmask = 4'b0001; end
                        4: pc_wdata[1:0] = 2'($urandom_range(1, 3));
                        default: begin trap = 1'b1; pc_wdata[1:0] = 2'b10; end
                    endcase
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
